// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and default bus widths
// Purpose: one-hot APB phase encoding shared by the initiator and the
//          SRAM-side slave control block, plus default address/data widths.
// Ports:   none (package).
package apb_pkg;

    localparam logic [2:0] IDLE   = 3'b001;
    localparam logic [2:0] SETUP  = 3'b010;
    localparam logic [2:0] ACCESS = 3'b100;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_SETUP  = SETUP,
        ST_ACCESS = ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB bus signal bundle with initiator/target views
// Purpose: groups the APB request and completion wires.
// Ports:   master modport drives psel/penable/pwrite/paddr/pwdata and
//          observes pready/prdata/pslverr; slave modport is the mirror.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS-phase wait-state counter with timeout flag
// Purpose: counts ACCESS cycles spent with pready low and flags the cycle
//          in which the transfer must be abandoned.
// Ports:   pclk, prstn (async active-low); clear restarts the count;
//          enable advances it; pready suppresses the flag (ready wins);
//          timeout_hit is combinational. TIMEOUT=0 never flags.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clear,
    input  logic enable,
    input  logic pready,
    output logic timeout_hit
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LIMIT) && !pready;

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator sequencing single commands into transfers
// Purpose: accepts read/write commands, runs APB SETUP/ACCESS phases, waits
//          on pready (bounded by TIMEOUT) and returns a one-cycle response.
// Ports:   pclk, prstn (async active-low); cmd_* valid/ready command port;
//          rsp_* one-cycle response; apb = APB bus (master modport).
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_master_if.master      apb
);

    apb_state_e        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic timeout_hit;
    logic done;
    logic in_access;
    logic accept;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .pclk        (pclk),
        .prstn       (prstn),
        .clear       (accept),
        .enable      (in_access && !done),
        .pready      (apb.pready),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        in_access = (state_q == ST_ACCESS);
        done      = apb.pready || timeout_hit;
        // Gated by prstn so nothing is accepted while reset is held.
        cmd_ready = prstn && ((state_q == ST_IDLE) || (in_access && done));
        accept    = cmd_valid && cmd_ready;

        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (done) state_d = accept ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
            pwdata_d = cmd_wdata;
        end

        // In ACCESS psel and penable are both high, so pslverr is only
        // looked at in the qualified completion cycle.
        rsp_valid_d = in_access && done;
        if (rsp_valid_d) begin
            rsp_err_d   = timeout_hit || (apb.pready && apb.pslverr);
            rsp_rdata_d = (!pwrite_q && apb.pready && !apb.pslverr) ? apb.prdata : '0;
        end

        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
// Purpose: drives the command port and APB completion signals with directed
//          steps and checks bus and response outputs at each falling edge.
// Ports:   none (top-level bench).
module tb_apb_master;

    logic        pclk;
    logic        prstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(4)) dut (
        .pclk      (pclk),
        .prstn     (prstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic s, input logic e);
        chk({tag, ".psel"}, {31'd0, bus.psel}, {31'd0, s});
        chk({tag, ".penable"}, {31'd0, bus.penable}, {31'd0, e});
    endtask

    initial begin
        prstn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus.pready = 1'b1; bus.prdata = '0; bus.pslverr = 1'b0;

        // Reset state
        repeat (2) @(negedge pclk);
        chk_bus("rst", 1'b0, 1'b0);
        chk("rst.pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("rst.paddr", {20'd0, bus.paddr}, 32'd0);
        chk("rst.pwdata", bus.pwdata, 32'd0);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        prstn = 1'b1;
        @(negedge pclk);
        chk("idle.cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write, zero wait states
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h014; cmd_wdata = 32'hDEADBEEF;
        @(negedge pclk);
        chk_bus("wr.setup", 1'b1, 1'b0);
        chk("wr.paddr", {20'd0, bus.paddr}, 32'h014);
        chk("wr.pwdata", bus.pwdata, 32'hDEADBEEF);
        chk("wr.pwrite", {31'd0, bus.pwrite}, 32'd1);
        chk("wr.setup.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("wr.setup.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk_bus("wr.access", 1'b1, 1'b1);
        chk("wr.access.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge pclk);
        chk("wr.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("wr.rsp_rdata", rsp_rdata, 32'd0);
        chk_bus("wr.idle", 1'b0, 1'b0);
        @(negedge pclk);
        chk("wr.rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // Read with two wait states
        bus.pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
        @(negedge pclk);
        chk_bus("rd.setup", 1'b1, 1'b0);
        chk("rd.paddr", {20'd0, bus.paddr}, 32'h020);
        chk("rd.pwrite", {31'd0, bus.pwrite}, 32'd0);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk_bus("rd.access1", 1'b1, 1'b1);
        chk("rd.access1.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge pclk);
        chk_bus("rd.access2", 1'b1, 1'b1);
        chk("rd.access2.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge pclk);
        chk_bus("rd.access3", 1'b1, 1'b1);
        bus.pready = 1'b1; bus.prdata = 32'h12345678;
        @(negedge pclk);
        bus.prdata = '0;
        chk("rd.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd.rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk_bus("rd.idle", 1'b0, 1'b0);
        @(negedge pclk);
        chk("rd.rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("rd.rsp_hold", rsp_rdata, 32'h12345678);

        // Back-to-back: write 0x004 then read 0x008
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'h11112222;
        bus.prdata = 32'hCAFEF00D;
        @(negedge pclk);
        chk_bus("b2b.setup1", 1'b1, 1'b0);
        chk("b2b.paddr1", {20'd0, bus.paddr}, 32'h004);
        cmd_write = 1'b0; cmd_addr = 12'h008;
        @(negedge pclk);
        chk_bus("b2b.access1", 1'b1, 1'b1);
        chk("b2b.access1.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge pclk);
        chk_bus("b2b.setup2", 1'b1, 1'b0);
        chk("b2b.paddr2", {20'd0, bus.paddr}, 32'h008);
        chk("b2b.pwrite2", {31'd0, bus.pwrite}, 32'd0);
        chk("b2b.rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b.rsp1_rdata", rsp_rdata, 32'd0);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk_bus("b2b.access2", 1'b1, 1'b1);
        chk("b2b.gap", {31'd0, rsp_valid}, 32'd0);
        @(negedge pclk);
        chk("b2b.rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b.rsp2_rdata", rsp_rdata, 32'hCAFEF00D);
        chk_bus("b2b.idle", 1'b0, 1'b0);

        // Read completed with pslverr
        bus.pslverr = 1'b1; bus.prdata = 32'h55555555;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h00C;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk_bus("err.access", 1'b1, 1'b1);
        @(negedge pclk);
        bus.pslverr = 1'b0; bus.prdata = '0;
        chk("err.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("err.rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("err.rsp_rdata", rsp_rdata, 32'd0);

        // Timeout: TIMEOUT=4, pready stuck low
        bus.pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
        @(negedge pclk);
        chk_bus("to.setup", 1'b1, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            chk_bus($sformatf("to.access%0d", i), 1'b1, 1'b1);
            chk($sformatf("to.access%0d.cmd_ready", i), {31'd0, cmd_ready}, (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge pclk);
        chk_bus("to.idle", 1'b0, 1'b0);
        chk("to.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to.rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to.rsp_rdata", rsp_rdata, 32'd0);
        bus.pready = 1'b1;

        // Unaligned address is forced to word alignment
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h017; cmd_wdata = 32'h0000A5A5;
        @(negedge pclk);
        chk("ua.paddr", {20'd0, bus.paddr}, 32'h014);
        chk("ua.pwdata", bus.pwdata, 32'h0000A5A5);
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("ua.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ua.rsp_err", {31'd0, rsp_err}, 32'd0);

        // Reset mid-ACCESS
        bus.pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk_bus("mr.access", 1'b1, 1'b1);
        #2 prstn = 1'b0;
        #1;
        chk_bus("mr.async", 1'b0, 1'b0);
        chk("mr.async.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr.async.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge pclk);
        prstn = 1'b1;
        bus.pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk($sformatf("mr.after%0d.rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("mr.after%0d.cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
            chk_bus($sformatf("mr.after%0d", i), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator (bridge end) of the APB bus that the SRAM-side slave control block responds to.
- Accepts single read/write commands on a valid/ready command port and sequences them into APB IDLE→SETUP→ACCESS transfers.
- Waits on pready and returns read data and error status on a one-cycle response port.
- Sits between the system-side requester (CPU/DMA glue) and the APB slaves.

Parameters:
- ADDR_W, 12, APB address width (byte address; word aligned).
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout.

Ports:
- pclk  in  1  APB clock
- prstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  pslverr or timeout on the completed transfer
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  slave ready
- prdata  in  DATA_W  slave read data
- pslverr  in  1  slave error

Behaviour:
- Reset (prstn low, async): state=IDLE; psel=penable=pwrite=0; paddr=0; pwdata=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; timeout counter=0; cmd_ready=0 while prstn low.
- Reset mid-transfer: transfer dropped, no response issued, bus returns to idle immediately.
- FSM states, one-hot: IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100.
- cmd_ready = (state==IDLE) | (state==ACCESS & done), where done = pready | timeout_hit. Combinational from state and inputs.
- Accept (cmd_valid & cmd_ready): register pwrite=cmd_write, paddr={cmd_addr[ADDR_W-1:2],2'b00}, pwdata=cmd_wdata; next state=SETUP.
  - cmd_addr[1:0] is ignored; the address is forced word-aligned.
- IDLE: psel=0, penable=0. Accept → SETUP; otherwise stay in IDLE.
- SETUP, exactly 1 cycle: psel=1, penable=0. Always → ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable.
  - If !done: stay in ACCESS and increment the timeout counter.
  - If done and a new command is accepted the same cycle: → SETUP, with psel held high (back-to-back, no IDLE cycle).
  - If done and no command: → IDLE.
- timeout_hit = (TIMEOUT!=0) & (counter==TIMEOUT-1) & !pready. Counter clears on entry to SETUP.
  - A pready arriving in the same cycle as the limit counts as a normal completion (pready wins).
- Response, registered, valid the cycle after ACCESS completes: rsp_valid=1 for exactly 1 cycle.
  - rsp_err = timeout_hit | (pready & pslverr).
  - rsp_rdata = prdata for a read completed by pready without pslverr; 0 otherwise.
  - rsp_rdata and rsp_err hold their values until the next response.
- pslverr is sampled only when psel & penable & pready.
- Minimum transfer latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3 with zero wait states.
- psel and penable are never both high outside ACCESS; penable is never high without psel.

Decomposition:
- Shared package apb_pkg holds:
  - state localparams IDLE/SETUP/ACCESS (3'b001/3'b010/3'b100), shared with the slave control block;
  - default ADDR_W=12 and DATA_W=32.
- One natural sub-module: apb_wait_timer (counter, clear, enable, timeout_hit output, parameter TIMEOUT).
- The FSM and bus/response registers stay in apb_master.

Test Plan:
- Write, zero wait: cmd write addr=0x014, wdata=0xDEADBEEF, pready=1 → paddr=0x014, pwdata=0xDEADBEEF, SETUP 1 cycle then ACCESS 1 cycle; rsp_valid 3 cycles after accept, rsp_err=0.
- Read with 2 wait states: cmd read addr=0x020; pready low 2 ACCESS cycles, then high with prdata=0x12345678 → ACCESS lasts 3 cycles, rsp_rdata=0x12345678, rsp_err=0.
- Back-to-back: cmd_valid held high with write 0x004 then read 0x008, pready=1 → psel stays 1 across both transfers, no IDLE cycle, two rsp_valid pulses 2 cycles apart.
- Error and timeout:
  - Read with pslverr=1 on completion → rsp_err=1, rsp_rdata=0.
  - TIMEOUT=4 with pready stuck 0 → ACCESS exactly 4 cycles, then IDLE, rsp_err=1.
- Unaligned address: cmd addr=0x017 → paddr=0x014.
- Reset mid-ACCESS: deassert prstn while penable=1 → psel, penable and rsp_valid go 0 asynchronously; after release, state is IDLE, cmd_ready=1, and no response is issued for the dropped transfer.
